// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: stages, opcodes,
// ALU/memory operation codes, datapath mux selects and small decode helpers.
package rv32_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_FETCH     = 5'd0,
        ST_DECODE    = 5'd1,
        ST_EXEC_R    = 5'd2,
        ST_EXEC_I    = 5'd3,
        ST_ALU_WB    = 5'd4,
        ST_BRANCH    = 5'd5,
        ST_JAL       = 5'd6,
        ST_JALR      = 5'd7,
        ST_MEM_ADDR  = 5'd8,
        ST_MEM_WRITE = 5'd9,
        ST_MEM_READ  = 5'd10,
        ST_MEM_WB    = 5'd11,
        ST_LUI       = 5'd12,
        ST_AUIPC     = 5'd13,
        ST_ERROR     = 5'd14
    } stage_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1011;
    localparam logic [3:0] ALU_AND  = 4'b1100;

    localparam logic [3:0] MEM_LB  = 4'b0000;
    localparam logic [3:0] MEM_LH  = 4'b0001;
    localparam logic [3:0] MEM_LW  = 4'b0010;
    localparam logic [3:0] MEM_LBU = 4'b0100;
    localparam logic [3:0] MEM_LHU = 4'b0101;
    localparam logic [3:0] MEM_SB  = 4'b1000;
    localparam logic [3:0] MEM_SH  = 4'b1001;
    localparam logic [3:0] MEM_SW  = 4'b1010;

    // SRCA_ZERO lets LUI pass the immediate straight through an ADD.
    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RSA   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RSB  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic lt, input logic ltu);
        logic taken;
        taken = 1'b0;
        case (f3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational map from opcode/funct3/funct7 to an ALU-op or memory-op code,
// flagging encodings this core does not implement.
module alu_decoder
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] op_code,
    output logic       illegal
);

    always_comb begin
        op_code = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    op_code = alu_from_funct3(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    op_code = alu_from_funct3(funct3, 1'b1);
                end else begin
                    illegal = 1'b1;
                end
            end
            // Only the shift immediates carry a funct7; elsewhere those bits are immediate.
            OPC_OP_IMM: begin
                case (funct3)
                    3'b001: begin
                        op_code = ALU_SLL;
                        illegal = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        op_code = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                    default: op_code = alu_from_funct3(funct3, 1'b0);
                endcase
            end
            OPC_LOAD: begin
                case (funct3)
                    3'b000:  op_code = MEM_LB;
                    3'b001:  op_code = MEM_LH;
                    3'b010:  op_code = MEM_LW;
                    3'b100:  op_code = MEM_LBU;
                    3'b101:  op_code = MEM_LHU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                case (funct3)
                    3'b000:  op_code = MEM_SB;
                    3'b001:  op_code = MEM_SH;
                    3'b010:  op_code = MEM_SW;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                op_code = ALU_SUB;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: op_code = ALU_ADD;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM: sequences one instruction at a time and drives
// imem, PC, register-file and ALU/result mux controls from the current stage.
module mc_control_fsm
    import rv32_ctrl_pkg::*;
#(
    parameter logic [4:0] RESET_STAGE = 5'd0,
    parameter logic       ERR_STICKY  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_reg,
    input  logic        mem_ready,
    input  logic        zero,
    input  logic        lt,
    input  logic        ltu,
    output logic [4:0]  current_stage,
    output logic        IorD_reg,
    output logic        MemWrite_reg,
    output logic        IRWrite_reg,
    output logic [3:0]  AluControl_reg,
    output logic        PCWrite_reg,
    output logic        RegWrite_reg,
    output logic [1:0]  AluSrcA_reg,
    output logic [1:0]  AluSrcB_reg,
    output logic [1:0]  ResultSrc_reg,
    output logic        illegal_reg
);

    stage_e     state_q, state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] dec_code;
    logic       dec_illegal;
    logic       unused_instr_bits;

    assign opcode            = instruction_reg[6:0];
    assign funct3            = instruction_reg[14:12];
    assign funct7            = instruction_reg[31:25];
    assign unused_instr_bits = ^{instruction_reg[24:15], instruction_reg[11:7]};
    assign current_stage     = state_q;

    alu_decoder u_alu_decoder (
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7  (funct7),
        .op_code (dec_code),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= stage_e'(RESET_STAGE);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        IorD_reg       = 1'b0;
        MemWrite_reg   = 1'b0;
        IRWrite_reg    = 1'b0;
        AluControl_reg = ALU_ADD;
        PCWrite_reg    = 1'b0;
        RegWrite_reg   = 1'b0;
        AluSrcA_reg    = SRCA_PC;
        AluSrcB_reg    = SRCB_RSB;
        ResultSrc_reg  = RES_ALUOUT;
        illegal_reg    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                AluSrcB_reg   = SRCB_FOUR;
                ResultSrc_reg = RES_ALU;
                IRWrite_reg   = mem_ready;
                PCWrite_reg   = mem_ready;
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                AluSrcA_reg = SRCA_OLDPC;
                AluSrcB_reg = SRCB_IMM;
                case (opcode)
                    OPC_OP:               state_d = ST_EXEC_R;
                    OPC_OP_IMM:           state_d = ST_EXEC_I;
                    OPC_LOAD, OPC_STORE:  state_d = ST_MEM_ADDR;
                    OPC_BRANCH:           state_d = ST_BRANCH;
                    OPC_JAL:              state_d = ST_JAL;
                    OPC_JALR:             state_d = ST_JALR;
                    OPC_LUI:              state_d = ST_LUI;
                    OPC_AUIPC:            state_d = ST_AUIPC;
                    default:              state_d = ST_ERROR;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: begin
                AluSrcA_reg    = SRCA_RSA;
                AluSrcB_reg    = (state_q == ST_EXEC_I) ? SRCB_IMM : SRCB_RSB;
                AluControl_reg = dec_code;
                state_d        = dec_illegal ? ST_ERROR : ST_ALU_WB;
            end
            // JALR left its target in AluOut, so the link is recomputed and written directly.
            ST_ALU_WB: begin
                RegWrite_reg   = 1'b1;
                AluControl_reg = dec_code;
                if (opcode == OPC_JALR) begin
                    AluSrcA_reg    = SRCA_OLDPC;
                    AluSrcB_reg    = SRCB_FOUR;
                    AluControl_reg = ALU_ADD;
                    ResultSrc_reg  = RES_ALU;
                end
                state_d = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                AluSrcA_reg = SRCA_RSA;
                AluSrcB_reg = SRCB_IMM;
                state_d     = (opcode == OPC_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_WRITE: begin
                IorD_reg       = 1'b1;
                AluControl_reg = dec_code;
                if (dec_illegal) begin
                    state_d = ST_ERROR;
                end else begin
                    MemWrite_reg = mem_ready;
                    if (mem_ready) state_d = ST_FETCH;
                end
            end
            ST_MEM_READ: begin
                IorD_reg       = 1'b1;
                AluControl_reg = dec_code;
                if (dec_illegal) begin
                    state_d = ST_ERROR;
                end else if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end
            end
            ST_MEM_WB: begin
                RegWrite_reg   = 1'b1;
                ResultSrc_reg  = RES_MEM;
                AluControl_reg = dec_code;
                state_d        = ST_FETCH;
            end
            ST_BRANCH: begin
                AluSrcA_reg    = SRCA_RSA;
                AluSrcB_reg    = SRCB_RSB;
                AluControl_reg = ALU_SUB;
                if (dec_illegal) begin
                    state_d = ST_ERROR;
                end else begin
                    PCWrite_reg = branch_taken(funct3, zero, lt, ltu);
                    state_d     = ST_FETCH;
                end
            end
            ST_JAL: begin
                PCWrite_reg = 1'b1;
                AluSrcA_reg = SRCA_OLDPC;
                AluSrcB_reg = SRCB_FOUR;
                state_d     = ST_ALU_WB;
            end
            ST_JALR: begin
                PCWrite_reg   = 1'b1;
                AluSrcA_reg   = SRCA_RSA;
                AluSrcB_reg   = SRCB_IMM;
                ResultSrc_reg = RES_ALU;
                state_d       = ST_ALU_WB;
            end
            ST_LUI: begin
                AluSrcA_reg = SRCA_ZERO;
                AluSrcB_reg = SRCB_IMM;
                state_d     = ST_ALU_WB;
            end
            ST_AUIPC: begin
                AluSrcA_reg = SRCA_OLDPC;
                AluSrcB_reg = SRCB_IMM;
                state_d     = ST_ALU_WB;
            end
            ST_ERROR: begin
                illegal_reg = 1'b1;
                state_d     = ERR_STICKY ? ST_ERROR : ST_FETCH;
            end
            default: state_d = ST_ERROR;
        endcase

        // Reset overrides everything immediately, aborting any in-flight write.
        if (!reset) begin
            IorD_reg       = 1'b0;
            MemWrite_reg   = 1'b0;
            IRWrite_reg    = 1'b0;
            AluControl_reg = 4'b0000;
            PCWrite_reg    = 1'b0;
            RegWrite_reg   = 1'b0;
            AluSrcA_reg    = 2'd0;
            AluSrcB_reg    = 2'd0;
            ResultSrc_reg  = 2'd0;
            illegal_reg    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks reset, R-type, store, load, branch,
// JAL and illegal instructions through the FSM against hand-derived stage traces.
module tb_mc_control_fsm;

    logic        clk;
    logic        reset;
    logic [31:0] instruction_reg;
    logic        mem_ready;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic [4:0]  current_stage;
    logic        IorD_reg;
    logic        MemWrite_reg;
    logic        IRWrite_reg;
    logic [3:0]  AluControl_reg;
    logic        PCWrite_reg;
    logic        RegWrite_reg;
    logic [1:0]  AluSrcA_reg;
    logic [1:0]  AluSrcB_reg;
    logic [1:0]  ResultSrc_reg;
    logic        illegal_reg;

    int checks;
    int errors;

    mc_control_fsm dut (
        .clk             (clk),
        .reset           (reset),
        .instruction_reg (instruction_reg),
        .mem_ready       (mem_ready),
        .zero            (zero),
        .lt              (lt),
        .ltu             (ltu),
        .current_stage   (current_stage),
        .IorD_reg        (IorD_reg),
        .MemWrite_reg    (MemWrite_reg),
        .IRWrite_reg     (IRWrite_reg),
        .AluControl_reg  (AluControl_reg),
        .PCWrite_reg     (PCWrite_reg),
        .RegWrite_reg    (RegWrite_reg),
        .AluSrcA_reg     (AluSrcA_reg),
        .AluSrcB_reg     (AluSrcB_reg),
        .ResultSrc_reg   (ResultSrc_reg),
        .illegal_reg     (illegal_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] instr, input logic rdy,
                                  input logic z, input logic l, input logic lu);
        instruction_reg = instr;
        mem_ready       = rdy;
        zero            = z;
        lt              = l;
        ltu             = lu;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [4:0] enables();
        return {IorD_reg, MemWrite_reg, IRWrite_reg, PCWrite_reg, RegWrite_reg};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        apply_stimulus(32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        repeat (2) tick();

        // Reset state: FETCH encoding but every enable and select forced low.
        check_output("rst_stage", current_stage, 5'd0);
        check_output("rst_enables", enables(), 5'b0);
        check_output("rst_srcb", AluSrcB_reg, 2'd0);
        check_output("rst_result", ResultSrc_reg, 2'd0);
        check_output("rst_illegal", illegal_reg, 1'b0);

        reset = 1'b1;
        #1;
        check_output("fetch_irwrite", IRWrite_reg, 1'b1);
        check_output("fetch_pcwrite", PCWrite_reg, 1'b1);
        check_output("fetch_srcb", AluSrcB_reg, 2'd2);

        // add x3,x1,x2: FETCH -> DECODE -> EXEC_R -> ALU_WB -> FETCH
        check_output("add_s0_regwrite", RegWrite_reg, 1'b0);
        tick();
        check_output("add_s1_stage", current_stage, 5'd1);
        check_output("add_s1_regwrite", RegWrite_reg, 1'b0);
        tick();
        check_output("add_s2_stage", current_stage, 5'd2);
        check_output("add_s2_aluctl", AluControl_reg, 4'b0000);
        check_output("add_s2_regwrite", RegWrite_reg, 1'b0);
        tick();
        check_output("add_s4_stage", current_stage, 5'd4);
        check_output("add_s4_regwrite", RegWrite_reg, 1'b1);
        check_output("add_s4_result", ResultSrc_reg, 2'd0);
        tick();
        check_output("add_done_stage", current_stage, 5'd0);

        // sw x2,0x200(x0) with mem_ready held low for two MEM_WRITE cycles
        apply_stimulus(32'h20202023, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("sw_s1_stage", current_stage, 5'd1);
        tick();
        check_output("sw_s8_stage", current_stage, 5'd8);
        mem_ready = 1'b0;
        tick();
        check_output("sw_s9a_stage", current_stage, 5'd9);
        check_output("sw_s9a_iord", IorD_reg, 1'b1);
        check_output("sw_s9a_aluctl", AluControl_reg, 4'b1010);
        check_output("sw_s9a_memwrite", MemWrite_reg, 1'b0);
        tick();
        check_output("sw_s9b_stage", current_stage, 5'd9);
        check_output("sw_s9b_memwrite", MemWrite_reg, 1'b0);
        mem_ready = 1'b1;
        #1;
        check_output("sw_s9c_memwrite", MemWrite_reg, 1'b1);
        tick();
        check_output("sw_done_stage", current_stage, 5'd0);
        check_output("sw_done_memwrite", MemWrite_reg, 1'b0);

        // lw x5,8(x0): FETCH -> DECODE -> MEM_ADDR -> MEM_READ -> MEM_WB -> FETCH
        apply_stimulus(32'h00802283, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("lw_s1_stage", current_stage, 5'd1);
        tick();
        check_output("lw_s8_stage", current_stage, 5'd8);
        tick();
        check_output("lw_s10_stage", current_stage, 5'd10);
        check_output("lw_s10_aluctl", AluControl_reg, 4'b0010);
        check_output("lw_s10_iord", IorD_reg, 1'b1);
        check_output("lw_s10_regwrite", RegWrite_reg, 1'b0);
        tick();
        check_output("lw_s11_stage", current_stage, 5'd11);
        check_output("lw_s11_aluctl", AluControl_reg, 4'b0010);
        check_output("lw_s11_regwrite", RegWrite_reg, 1'b1);
        check_output("lw_s11_result", ResultSrc_reg, 2'd1);
        tick();
        check_output("lw_done_stage", current_stage, 5'd0);

        // beq taken (zero=1) then not taken (zero=0); three cycles each
        for (int pass = 0; pass < 2; pass++) begin
            apply_stimulus(32'h00000463, 1'b1, (pass == 0), 1'b0, 1'b0);
            tick();
            check_output("beq_s1_stage", current_stage, 5'd1);
            check_output("beq_s1_pcwrite", PCWrite_reg, 1'b0);
            tick();
            check_output("beq_s5_stage", current_stage, 5'd5);
            check_output("beq_s5_aluctl", AluControl_reg, 4'b0001);
            check_output("beq_s5_pcwrite", PCWrite_reg, (pass == 0));
            tick();
            check_output("beq_done_stage", current_stage, 5'd0);
        end

        // jal x1,0: PC load in JAL stage, link write in ALU_WB
        apply_stimulus(32'h000000EF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_output("jal_s6_stage", current_stage, 5'd6);
        check_output("jal_s6_pcwrite", PCWrite_reg, 1'b1);
        check_output("jal_s6_srcb", AluSrcB_reg, 2'd2);
        tick();
        check_output("jal_s4_stage", current_stage, 5'd4);
        check_output("jal_s4_regwrite", RegWrite_reg, 1'b1);
        tick();

        // Reset asserted while a store is mid-strobe
        apply_stimulus(32'h20202023, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        check_output("rstmid_stage9", current_stage, 5'd9);
        mem_ready = 1'b1;
        #1;
        check_output("rstmid_memwrite_pre", MemWrite_reg, 1'b1);
        reset = 1'b0;
        #1;
        check_output("rstmid_memwrite", MemWrite_reg, 1'b0);
        check_output("rstmid_stage", current_stage, 5'd0);
        check_output("rstmid_enables", enables(), 5'b0);
        tick();
        reset = 1'b1;
        #1;
        check_output("rstmid_rel_irwrite", IRWrite_reg, 1'b1);
        check_output("rstmid_rel_pcwrite", PCWrite_reg, 1'b1);

        // R-type with unsupported funct7 (0000001) traps after EXEC_R
        apply_stimulus(32'h022081B3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_output("badf7_s2_stage", current_stage, 5'd2);
        tick();
        check_output("badf7_err_stage", current_stage, 5'd14);
        check_output("badf7_err_illegal", illegal_reg, 1'b1);
        reset = 1'b0;
        #1;
        tick();
        reset = 1'b1;
        #1;

        // Unknown opcode: sticky ERROR with all enables low until reset
        apply_stimulus(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("ill_s1_stage", current_stage, 5'd1);
        tick();
        for (int i = 0; i < 10; i++) begin
            check_output("ill_hold_stage", current_stage, 5'd14);
            check_output("ill_hold_flag", illegal_reg, 1'b1);
            check_output("ill_hold_enables", enables(), 5'b0);
            tick();
        end
        reset = 1'b0;
        #1;
        check_output("ill_rst_stage", current_stage, 5'd0);
        check_output("ill_rst_flag", illegal_reg, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        check_output("ill_rel_irwrite", IRWrite_reg, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
